// File: rtl/segment_7.sv
// Registered 4-bit to seven-segment decoder, seg bit order {g,f,e,d,c,b,a}.
// Define SEGMENT7_HEX_EN to show A,b,C,d,E,F for 10-15; otherwise those values blank.
module segment_7 #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_OFF = SEG_W'(0);
  localparam logic [SEG_W-1:0] BLANK   = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  logic [SEG_W-1:0] w_seg_hi;
  logic [SEG_W-1:0] w_seg;
  logic [SEG_W-1:0] r_seg;

  // Active-high decode; unused codes fall through to all segments off.
  always_comb begin
    w_seg_hi = SEG_OFF;
    case (bcd)
      4'd0:    w_seg_hi = 7'h3F;
      4'd1:    w_seg_hi = 7'h06;
      4'd2:    w_seg_hi = 7'h5B;
      4'd3:    w_seg_hi = 7'h4F;
      4'd4:    w_seg_hi = 7'h66;
      4'd5:    w_seg_hi = 7'h6D;
      4'd6:    w_seg_hi = 7'h7D;
      4'd7:    w_seg_hi = 7'h07;
      4'd8:    w_seg_hi = 7'h7F;
      4'd9:    w_seg_hi = 7'h6F;
`ifdef SEGMENT7_HEX_EN
      4'd10:   w_seg_hi = 7'h77;
      4'd11:   w_seg_hi = 7'h7C;
      4'd12:   w_seg_hi = 7'h39;
      4'd13:   w_seg_hi = 7'h5E;
      4'd14:   w_seg_hi = 7'h79;
      4'd15:   w_seg_hi = 7'h71;
`endif
      default: w_seg_hi = SEG_OFF;
    endcase
  end

  assign w_seg = ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;

  // Output register keeps the pins glitch-free; reset blanks without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= BLANK;
    end else begin
      r_seg <= w_seg;
    end
  end

  assign seg = r_seg;

endmodule

// File: tb/tb_segment_7.sv
// Self-checking bench for segment_7: both polarities side by side, vector table,
// reset/glitch sequences and a randomized run against a letter-based reference.
module tb_segment_7;

  logic       clk;
  logic       rst_n;
  logic [3:0] bcd;
  logic [6:0] seg_hi;
  logic [6:0] seg_lo;

  int n_cmp = 0;
  int n_err = 0;

  segment_7 #(.ACTIVE_LOW(1'b0)) u_dut_hi (.clk(clk), .rst_n(rst_n), .bcd(bcd), .seg(seg_hi));
  segment_7 #(.ACTIVE_LOW(1'b1)) u_dut_lo (.clk(clk), .rst_n(rst_n), .bcd(bcd), .seg(seg_lo));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] v;
    logic [6:0] exp_hi;
    logic [6:0] exp_lo;
  } vec_t;

  vec_t vecs[16];

  // Reference: light the named segments of each glyph, then apply polarity.
  function automatic logic [6:0] ref_seg(input int v, input bit active_low);
    string glyph[16];
    logic [6:0] p;
    glyph = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
              "abcdefg", "abcdfg", "", "", "", "", "", ""};
`ifdef SEGMENT7_HEX_EN
    glyph[10] = "abcefg";
    glyph[11] = "cdefg";
    glyph[12] = "adef";
    glyph[13] = "bcdeg";
    glyph[14] = "adefg";
    glyph[15] = "aefg";
`endif
    p = 7'h00;
    for (int i = 0; i < glyph[v].len(); i++) begin
      p[3'(int'(glyph[v][i]) - 97)] = 1'b1;
    end
    return active_low ? ~p : p;
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] hex_hi[6];
    int prev;
    int v;

`ifdef SEGMENT7_HEX_EN
    hex_hi = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`else
    hex_hi = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`endif
    vecs[0] = '{4'd0, 7'h3F, 7'h40};
    vecs[1] = '{4'd1, 7'h06, 7'h79};
    vecs[2] = '{4'd2, 7'h5B, 7'h24};
    vecs[3] = '{4'd3, 7'h4F, 7'h30};
    vecs[4] = '{4'd4, 7'h66, 7'h19};
    vecs[5] = '{4'd5, 7'h6D, 7'h12};
    vecs[6] = '{4'd6, 7'h7D, 7'h02};
    vecs[7] = '{4'd7, 7'h07, 7'h78};
    vecs[8] = '{4'd8, 7'h7F, 7'h00};
    vecs[9] = '{4'd9, 7'h6F, 7'h10};
    for (int i = 0; i < 6; i++) begin
      vecs[10+i] = '{4'(10 + i), hex_hi[i], ~hex_hi[i]};
    end

    // Reset held with clock running and bcd=8.
    rst_n = 1'b0;
    bcd   = 4'd8;
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      chk("reset_hold_hi", seg_hi, 7'h00);
      chk("reset_hold_lo", seg_lo, 7'h7F);
    end
    rst_n = 1'b1;
    #1;
    chk("release_no_edge_hi", seg_hi, 7'h00);
    edge_sample();
    chk("first_decode_hi", seg_hi, 7'h7F);
    chk("first_decode_lo", seg_lo, 7'h00);

    // Vector table: 0..15, one per cycle, 1-cycle latency.
    for (int i = 0; i < 16; i++) begin
      bcd = vecs[i].v;
      edge_sample();
      chk($sformatf("vec%0d_hi", i), seg_hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), seg_lo, vecs[i].exp_lo);
    end

    // Async reset mid-run between edges.
    bcd = 4'd3;
    edge_sample();
    chk("pre_reset_hi", seg_hi, 7'h4F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_hi", seg_hi, 7'h00);
    chk("async_reset_lo", seg_lo, 7'h7F);
    rst_n = 1'b1;
    #1;
    chk("after_release_hi", seg_hi, 7'h00);
    edge_sample();
    chk("recover_hi", seg_hi, 7'h4F);
    chk("recover_lo", seg_lo, 7'h30);

    // Input glitch 2->5->2 inside one period.
    bcd = 4'd2;
    edge_sample();
    for (int t = 0; t < 8; t++) begin
      if (t == 2) bcd = 4'd5;
      if (t == 4) bcd = 4'd2;
      #1;
      chk("glitch_hold_hi", seg_hi, 7'h5B);
    end
    edge_sample();
    chk("glitch_after_hi", seg_hi, 7'h5B);
    chk("glitch_after_lo", seg_lo, 7'h24);

    // Randomized run against the reference model, including mid-cycle hold.
    prev = 2;
    for (int i = 0; i < 300; i++) begin
      v = int'($urandom_range(15, 0));
      bcd = 4'(v);
      #4;
      chk("rand_hold_hi", seg_hi, ref_seg(prev, 1'b0));
      edge_sample();
      chk("rand_hi", seg_hi, ref_seg(v, 1'b0));
      chk("rand_lo", seg_lo, ref_seg(v, 1'b1));
      prev = v;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
